// File: rtl/enemy_sprite_ctrl.sv
// Patrol-enemy controller and renderer: WALK/FROZEN/DEAD behaviour plus a pipelined sprite ROM lookup.
// col/row -> rom_addr/rom_frame takes 1 cycle; rom_addr -> vga_enemy/pix_valid takes 2 more (ROM read, output register).
module enemy_sprite_ctrl #(
    parameter int          SPR_W         = 34,
    parameter int          SPR_H         = 33,
    parameter int          AW            = $clog2(SPR_W*SPR_H),
    parameter int          X0            = 240,
    parameter int          Y0            = 277,
    parameter int          STEP          = 1,
    parameter int          SPAN          = 64,
    parameter int          WALK_TICKS    = 3,
    parameter int          FZ_T0         = 2,
    parameter int          FZ_T1         = 6,
    parameter int          FREEZE_TICKS  = 120,
    parameter int          RESPAWN_TICKS = 240,
    parameter int          KEY_EN        = 1,
    parameter logic [11:0] TRANSPARENT   = 12'h000
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          freeze_req,
    input  logic          hit,
    input  logic [9:0]    col_addr_x,
    input  logic [8:0]    row_addr_y,
    input  logic [11:0]   rom_data,
    output logic [AW-1:0] rom_addr,
    output logic [2:0]    rom_frame,
    output logic [11:0]   vga_enemy,
    output logic          pix_valid,
    output logic [9:0]    x_pos,
    output logic [8:0]    y_pos,
    output logic          facing,
    output logic [1:0]    st
);

    typedef enum logic [1:0] {
        S_WALK   = 2'd0,
        S_FROZEN = 2'd1,
        S_DEAD   = 2'd2
    } state_e;

    localparam int CW = 16;

    state_e          state_q, state_d;
    logic [9:0]      x_q, x_d;
    logic            facing_q, facing_d;
    logic [CW-1:0]   leg_q, leg_d;
    logic [CW-1:0]   wtick_q, wtick_d;
    logic [1:0]      wph_q, wph_d;
    logic [CW-1:0]   fz_q, fz_d;
    logic [CW-1:0]   dead_q, dead_d;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        facing_d = facing_q;
        leg_d    = leg_q;
        wtick_d  = wtick_q;
        wph_d    = wph_q;
        fz_d     = fz_q;
        dead_d   = dead_q;
        case (state_q)
            S_WALK: begin
                if (hit) begin
                    state_d = S_DEAD;
                    dead_d  = '0;
                end else if (freeze_req) begin
                    state_d = S_FROZEN;
                    fz_d    = '0;
                end else if (tick) begin
                    x_d = facing_q ? x_q + 10'(STEP) : x_q - 10'(STEP);
                    if (leg_q == CW'(SPAN-1)) begin
                        leg_d    = '0;
                        facing_d = ~facing_q;
                    end else begin
                        leg_d = leg_q + 1'b1;
                    end
                    if (wtick_q == CW'(WALK_TICKS-1)) begin
                        wtick_d = '0;
                        wph_d   = (wph_q == 2'd2) ? 2'd0 : wph_q + 2'd1;
                    end else begin
                        wtick_d = wtick_q + 1'b1;
                    end
                end
            end
            S_FROZEN: begin
                if (hit) begin
                    state_d = S_DEAD;
                    dead_d  = '0;
                end else if (freeze_req) begin
                    fz_d = '0;
                end else if (tick) begin
                    if (fz_q == CW'(FREEZE_TICKS-1)) begin
                        state_d = S_WALK;
                        fz_d    = '0;
                    end else begin
                        fz_d = fz_q + 1'b1;
                    end
                end
            end
            S_DEAD: begin
                if (tick) begin
                    if (RESPAWN_TICKS != 0 && dead_q == CW'(RESPAWN_TICKS-1)) begin
                        state_d  = S_WALK;
                        x_d      = 10'(X0);
                        facing_d = 1'b0;
                        leg_d    = '0;
                        wtick_d  = '0;
                        wph_d    = '0;
                        fz_d     = '0;
                        dead_d   = '0;
                    end else begin
                        dead_d = dead_q + 1'b1;
                    end
                end
            end
            default: state_d = S_WALK;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_WALK;
            x_q      <= 10'(X0);
            facing_q <= 1'b0;
            leg_q    <= '0;
            wtick_q  <= '0;
            wph_q    <= '0;
            fz_q     <= '0;
            dead_q   <= '0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            facing_q <= facing_d;
            leg_q    <= leg_d;
            wtick_q  <= wtick_d;
            wph_q    <= wph_d;
            fz_q     <= fz_d;
            dead_q   <= dead_d;
        end
    end

    // Stage 0: 11-bit box compare so x_pos+SPR_W-1 never wraps.
    logic [10:0]   col_w, row_w, x_w, y_w, x_end, y_end, dx, dy, dxm;
    logic          in_box;
    logic [AW-1:0] addr_d;
    logic [2:0]    frame_d;

    always_comb begin
        col_w  = {1'b0, col_addr_x};
        row_w  = {2'b00, row_addr_y};
        x_w    = {1'b0, x_q};
        y_w    = 11'(Y0);
        x_end  = x_w + 11'(SPR_W-1);
        y_end  = y_w + 11'(SPR_H-1);
        in_box = (col_w >= x_w) && (col_w <= x_end) && (row_w >= y_w) && (row_w <= y_end);
        dx     = col_w - x_w;
        dy     = row_w - y_w;
        dxm    = facing_q ? (11'(SPR_W-1) - dx) : dx;
        addr_d = in_box ? AW'(32'(dy) * 32'(SPR_W) + 32'(dxm)) : '0;
        if (state_q == S_FROZEN) begin
            if (fz_q < CW'(FZ_T0))              frame_d = 3'd3;
            else if (fz_q < CW'(FZ_T0 + FZ_T1)) frame_d = 3'd4;
            else                                frame_d = 3'd5;
        end else begin
            frame_d = {1'b0, wph_q};
        end
    end

    logic          live0_q, live1_q, pix_q;
    logic [AW-1:0] rom_addr_q;
    logic [2:0]    rom_frame_q;
    logic [11:0]   vga_q;
    logic          opaque;

    assign opaque = live1_q && ((KEY_EN == 0) || (rom_data != TRANSPARENT));

    always_ff @(posedge clk) begin
        if (rst) begin
            live0_q     <= 1'b0;
            rom_addr_q  <= '0;
            rom_frame_q <= '0;
            live1_q     <= 1'b0;
            pix_q       <= 1'b0;
            vga_q       <= '0;
        end else begin
            live0_q     <= in_box && (state_q != S_DEAD);
            rom_addr_q  <= addr_d;
            rom_frame_q <= frame_d;
            live1_q     <= live0_q;
            pix_q       <= opaque;
            vga_q       <= opaque ? rom_data : 12'h000;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_frame = rom_frame_q;
    assign vga_enemy = vga_q;
    assign pix_valid = pix_q;
    assign x_pos     = x_q;
    assign y_pos     = 9'(Y0);
    assign facing    = facing_q;
    assign st        = state_q;

endmodule

// File: tb/tb_enemy_sprite_ctrl.sv
// Self-checking bench for enemy_sprite_ctrl: behavioural ROM, scoreboard for the pixel pipeline, direct state checks.
module tb_enemy_sprite_ctrl;

    localparam int AW = 11;

    logic          clk, rst, tick, freeze_req, hit;
    logic [9:0]    col_addr_x;
    logic [8:0]    row_addr_y;
    logic [11:0]   rom_data;
    logic [AW-1:0] rom_addr;
    logic [2:0]    rom_frame;
    logic [11:0]   vga_enemy;
    logic          pix_valid;
    logic [9:0]    x_pos;
    logic [8:0]    y_pos;
    logic          facing;
    logic [1:0]    st;

    enemy_sprite_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .freeze_req(freeze_req), .hit(hit),
        .col_addr_x(col_addr_x), .row_addr_y(row_addr_y), .rom_data(rom_data),
        .rom_addr(rom_addr), .rom_frame(rom_frame), .vga_enemy(vga_enemy),
        .pix_valid(pix_valid), .x_pos(x_pos), .y_pos(y_pos), .facing(facing), .st(st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Behavioural ROM: every 5th address is transparent black, the rest have the MSB set.
    logic        force_en;
    logic [11:0] force_val;

    function automatic logic [11:0] rom_fn(input logic [2:0] f, input logic [10:0] a);
        logic [10:0] t;
        if (a % 11'd5 == 11'd0) return 12'h000;
        t = (a * 11'd3) ^ {f, 8'h00};
        return {1'b1, t};
    endfunction

    always @(posedge clk) rom_data <= force_en ? force_val : rom_fn(rom_frame, rom_addr);

    typedef struct {
        int            due;
        logic [AW-1:0] addr;
        logic [2:0]    frame;
        bit            chk_frame;
    } a_exp_t;

    typedef struct {
        int          due;
        logic [11:0] vga;
        logic        pix;
    } p_exp_t;

    a_exp_t aq[$];
    p_exp_t pq[$];
    a_exp_t ae;
    p_exp_t pe;

    always @(negedge clk) begin
        while (aq.size() != 0 && aq[0].due <= cyc) begin
            ae = aq.pop_front();
            check("rom_addr", 32'(rom_addr), 32'(ae.addr));
            if (ae.chk_frame) check("scan_frame", 32'(rom_frame), 32'(ae.frame));
        end
        while (pq.size() != 0 && pq[0].due <= cyc) begin
            pe = pq.pop_front();
            check("pix_valid", 32'(pix_valid), 32'(pe.pix));
            check("vga_enemy", 32'(vga_enemy), 32'(pe.vga));
        end
    end

    // Reference enemy state, updated by the stimulus as it predicts each change.
    int m_x, m_face, m_st, m_frame;
    localparam int M_Y = 277;

    task automatic scan_pt(input int c, input int r);
        bit          inb;
        int          a;
        logic [11:0] d;
        bit          p;
        @(negedge clk);
        col_addr_x = 10'(c);
        row_addr_y = 9'(r);
        inb = (c >= m_x) && (c <= m_x + 33) && (r >= M_Y) && (r <= M_Y + 32);
        a   = inb ? (r - M_Y) * 34 + (m_face != 0 ? 33 - (c - m_x) : c - m_x) : 0;
        aq.push_back('{cyc + 1, AW'(a), 3'(m_frame), m_st != 2});
        d = force_en ? force_val : rom_fn(3'(m_frame), 11'(a));
        p = inb && (m_st != 2) && (d != 12'h000);
        pq.push_back('{cyc + 3, p ? d : 12'h000, p});
    endtask

    task automatic drain();
        repeat (4) @(negedge clk);
    endtask

    task automatic scan_box();
        int ox[8] = '{0, 1, 0, 33, 34, -1, 0, 5};
        int oy[8] = '{0, 0, 1, 32, 0, 0, 33, 7};
        for (int i = 0; i < 8; i++) scan_pt(m_x + ox[i], M_Y + oy[i]);
        drain();
    endtask

    task automatic tick_once();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
    endtask

    task automatic frame_after(input string tag, input int exp);
        @(negedge clk);
        check(tag, 32'(rom_frame), 32'(exp));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; tick = 1'b0; freeze_req = 1'b0; hit = 1'b0;
        col_addr_x = '0; row_addr_y = '0; force_en = 1'b0; force_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_x", 32'(x_pos), 240);
        check("rst_y", 32'(y_pos), 277);
        check("rst_facing", 32'(facing), 0);
        check("rst_st", 32'(st), 0);
        check("rst_addr", 32'(rom_addr), 0);
        check("rst_frame", 32'(rom_frame), 0);
        check("rst_pix", 32'(pix_valid), 0);
        check("rst_vga", 32'(vga_enemy), 0);
        rst = 1'b0;

        m_x = 240; m_face = 0; m_st = 0; m_frame = 0;
        scan_box();

        // Keying: black is transparent, red is opaque.
        force_en = 1'b1; force_val = 12'h000;
        scan_pt(240, 277); drain();
        force_val = 12'hF00;
        scan_pt(240, 277); scan_pt(273, 309); drain();
        force_en = 1'b0;

        for (int k = 1; k <= 64; k++) begin
            tick_once();
            check("walk_l_x", 32'(x_pos), 32'(240 - k));
            check("walk_l_face", 32'(facing), (k == 64) ? 1 : 0);
        end
        m_x = 176; m_face = 1; m_frame = 0;
        scan_box();

        for (int k = 1; k <= 64; k++) begin
            tick_once();
            check("walk_r_x", 32'(x_pos), 32'(176 + k));
            check("walk_r_face", 32'(facing), (k == 64) ? 0 : 1);
        end

        repeat (10) tick_once();
        check("x_230", 32'(x_pos), 230);
        m_x = 230; m_face = 0; m_frame = 1;
        scan_box();

        // Freeze on a tick cycle: no movement.
        @(negedge clk) begin tick = 1'b1; freeze_req = 1'b1; end
        @(negedge clk) begin tick = 1'b0; freeze_req = 1'b0; end
        check("fz_x_hold", 32'(x_pos), 230);
        check("fz_st", 32'(st), 1);
        frame_after("fz_frame0", 3);
        for (int k = 1; k <= 9; k++) begin
            tick_once();
            frame_after("fz_frame", (k < 2) ? 3 : (k < 8) ? 4 : 5);
        end
        repeat (91) tick_once();
        @(negedge clk) freeze_req = 1'b1;
        @(negedge clk) freeze_req = 1'b0;
        frame_after("refz_frame", 3);
        check("refz_st", 32'(st), 1);
        repeat (119) tick_once();
        check("thaw_not_yet", 32'(st), 1);
        tick_once();
        check("thaw_st", 32'(st), 0);
        check("thaw_x", 32'(x_pos), 230);
        tick_once();
        check("resume_x", 32'(x_pos), 229);
        frame_after("resume_frame", 1);

        // Hit wins over freeze; dead sprite is never visible.
        @(negedge clk) begin hit = 1'b1; freeze_req = 1'b1; end
        @(negedge clk) begin hit = 1'b0; freeze_req = 1'b0; end
        check("dead_st", 32'(st), 2);
        m_x = 229; m_st = 2;
        force_en = 1'b1; force_val = 12'hF00;
        scan_box();
        force_en = 1'b0;
        repeat (239) tick_once();
        check("dead_hold", 32'(st), 2);
        tick_once();
        check("respawn_st", 32'(st), 0);
        check("respawn_x", 32'(x_pos), 240);
        check("respawn_face", 32'(facing), 0);
        frame_after("respawn_frame", 0);

        // Reset mid-freeze with the scan inside the box.
        @(negedge clk) freeze_req = 1'b1;
        @(negedge clk) freeze_req = 1'b0;
        repeat (5) tick_once();
        check("pre_rst_st", 32'(st), 1);
        col_addr_x = 10'd245; row_addr_y = 9'd280;
        @(negedge clk) rst = 1'b1;
        @(negedge clk);
        check("mid_rst_st", 32'(st), 0);
        check("mid_rst_x", 32'(x_pos), 240);
        check("mid_rst_addr", 32'(rom_addr), 0);
        check("mid_rst_frame", 32'(rom_frame), 0);
        check("mid_rst_pix", 32'(pix_valid), 0);
        check("mid_rst_vga", 32'(vga_enemy), 0);
        rst = 1'b0;
        @(negedge clk);
        check("refill_pix", 32'(pix_valid), 0);

        check("sb_empty", 32'(aq.size() + pq.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
